// File: rtl/regfile_pkg.sv
// Shared constants for the register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int DEF_DATA_W = XLEN;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_IDX   = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue, cleared on
// writeback (set wins on collision), plus a running count of pending bits.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic             setEn;
    logic             clrEn;

    assign setEn = iss_valid && !(ZERO_REG && iss_rd == ADDR_W'(ZERO_IDX));
    assign clrEn = wb_en;

    // Next pending bits and count; the younger issuing instruction wins a collision.
    always_comb begin
        pend_d = pend_q;
        cnt_d  = cnt_q;
        if (clrEn) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (setEn) begin
            pend_d[iss_rd] = 1'b1;
        end
        if (setEn && !pend_q[iss_rd]) begin
            cnt_d = cnt_d + CNT_ONE;
        end
        if (clrEn && pend_q[wb_addr] && !(setEn && iss_rd == wb_addr)) begin
            cnt_d = cnt_d - CNT_ONE;
        end
    end

    // Scoreboard state register; reset drops every outstanding writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // A same-cycle writeback resolves the hazard since the bypass supplies the data.
    always_comb begin
        rs1_busy = pend_q[rs1_addr] && !(wb_en && wb_addr == rs1_addr);
        rs2_busy = pend_q[rs2_addr] && !(wb_en && wb_addr == rs2_addr);
    end

    assign pend_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with writeback bypass and integrated scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W:0]   pend_cnt
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wrEn;

    assign wrEn = wb_en && !(ZERO_REG && wb_addr == ADDR_W'(ZERO_IDX));

    // Data array: cleared on reset, written by the writeback stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrEn) begin
            mem_q[wb_addr] <= wb_data;
        end
    end

    // Read port 1: hardwired zero, then bypass (suppressed in reset), then storage.
    always_comb begin
        rs1_data = mem_q[rs1_addr];
        if (ZERO_REG && rs1_addr == ADDR_W'(ZERO_IDX)) begin
            rs1_data = '0;
        end else if (rst_n && wrEn && wb_addr == rs1_addr) begin
            rs1_data = wb_data;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rs2_data = mem_q[rs2_addr];
        if (ZERO_REG && rs2_addr == ADDR_W'(ZERO_IDX)) begin
            rs2_data = '0;
        end else if (rst_n && wrEn && wb_addr == rs2_addr) begin
            rs2_data = wb_data;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .pend_cnt  (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default 32x32 instance and a 64-bit x 16 instance.
module tb_regfile_sb;

    logic clk;

    // Default instance (DATA_W=32, ADDR_W=5, ZERO_REG=1)
    logic        rstN;
    logic [4:0]  rs1Addr, rs2Addr, issRd, wbAddr;
    logic [31:0] rs1Data, rs2Data, wbData;
    logic        rs1Busy, rs2Busy, issValid, wbEn;
    logic [5:0]  pendCnt;

    // Wide instance (DATA_W=64, ADDR_W=4, ZERO_REG=1)
    logic        bRstN;
    logic [3:0]  bRs1Addr, bRs2Addr, bIssRd, bWbAddr;
    logic [63:0] bRs1Data, bRs2Data, bWbData;
    logic        bRs1Busy, bRs2Busy, bIssValid, bWbEn;
    logic [4:0]  bPendCnt;

    int vectorCount = 0;
    int missCount   = 0;

    regfile_sb dut (
        .clk       (clk),
        .rst_n     (rstN),
        .rs1_addr  (rs1Addr),
        .rs2_addr  (rs2Addr),
        .rs1_data  (rs1Data),
        .rs2_data  (rs2Data),
        .rs1_busy  (rs1Busy),
        .rs2_busy  (rs2Busy),
        .iss_valid (issValid),
        .iss_rd    (issRd),
        .wb_en     (wbEn),
        .wb_addr   (wbAddr),
        .wb_data   (wbData),
        .pend_cnt  (pendCnt)
    );

    regfile_sb #(
        .DATA_W   (64),
        .ADDR_W   (4),
        .ZERO_REG (1'b1)
    ) dutWide (
        .clk       (clk),
        .rst_n     (bRstN),
        .rs1_addr  (bRs1Addr),
        .rs2_addr  (bRs2Addr),
        .rs1_data  (bRs1Data),
        .rs2_data  (bRs2Data),
        .rs1_busy  (bRs1Busy),
        .rs2_busy  (bRs2Busy),
        .iss_valid (bIssValid),
        .iss_rd    (bIssRd),
        .wb_en     (bWbEn),
        .wb_addr   (bWbAddr),
        .wb_data   (bWbData),
        .pend_cnt  (bPendCnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge so inputs change and outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive the default instance for one cycle's worth of inputs.
    task automatic applyStimulus(input logic iv, input logic [4:0] rd,
                                 input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd,
                                 input logic [4:0] a1, input logic [4:0] a2);
        issValid = iv;
        issRd    = rd;
        wbEn     = we;
        wbAddr   = wa;
        wbData   = wd;
        rs1Addr  = a1;
        rs2Addr  = a2;
        #1;
    endtask

    // Drive the wide instance for one cycle's worth of inputs.
    task automatic applyWide(input logic iv, input logic [3:0] rd,
                             input logic we, input logic [3:0] wa,
                             input logic [63:0] wd,
                             input logic [3:0] a1, input logic [3:0] a2);
        bIssValid = iv;
        bIssRd    = rd;
        bWbEn     = we;
        bWbAddr   = wa;
        bWbData   = wd;
        bRs1Addr  = a1;
        bRs2Addr  = a2;
        #1;
    endtask

    initial begin
        rstN  = 1'b0;
        bRstN = 1'b0;
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        applyWide(1'b0, 4'd0, 1'b0, 4'd0, 64'h0, 4'd0, 4'd0);

        // Reset held: a writeback must not bypass, nothing busy
        applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd7);
        checkOutput("rst_no_bypass", 64'(rs1Data), 64'h0);
        checkOutput("rst_busy", 64'(rs2Busy), 64'h0);
        tick();
        checkOutput("rst_cnt", 64'(pendCnt), 64'h0);
        checkOutput("rst_no_write", 64'(rs1Data), 64'h0);
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        tick();
        rstN = 1'b1;

        // All addresses read zero after reset
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            checkOutput($sformatf("clr_rs1_%0d", a), 64'(rs1Data), 64'h0);
            checkOutput($sformatf("clr_rs2_%0d", a), 64'(rs2Data), 64'h0);
            checkOutput($sformatf("clr_busy_%0d", a), 64'({rs1Busy, rs2Busy}), 64'h0);
        end
        checkOutput("clr_cnt", 64'(pendCnt), 64'h0);

        // Write reg 5, visible through storage next cycle
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd5, 32'h15, 5'd1, 5'd2);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        checkOutput("wr5_read", 64'(rs1Data), 64'h15);

        // Same-cycle bypass on both ports
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd7);
        checkOutput("byp_rs1", 64'(rs1Data), 64'hDEADBEEF);
        checkOutput("byp_rs2", 64'(rs2Data), 64'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd5);
        checkOutput("byp_stored", 64'(rs1Data), 64'hDEADBEEF);
        checkOutput("wr5_hold", 64'(rs2Data), 64'h15);

        // Register 0 write and issue are both dropped
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        checkOutput("r0_no_bypass", 64'(rs1Data), 64'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("r0_read", 64'(rs1Data), 64'h0);
        checkOutput("r0_busy", 64'(rs1Busy), 64'h0);
        checkOutput("r0_cnt", 64'(pendCnt), 64'h0);

        // Issue rd=3: busy only from the next cycle
        applyStimulus(1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        checkOutput("iss3_same_busy", 64'(rs1Busy), 64'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        checkOutput("iss3_busy", 64'(rs1Busy), 64'h1);
        checkOutput("iss3_cnt", 64'(pendCnt), 64'h1);

        // Writeback to 3 resolves busy in the same cycle, count drops next cycle
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 5'd3, 5'd0);
        checkOutput("wb3_busy", 64'(rs1Busy), 64'h0);
        checkOutput("wb3_byp", 64'(rs1Data), 64'h33);
        checkOutput("wb3_cnt_same", 64'(pendCnt), 64'h1);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        checkOutput("wb3_cnt", 64'(pendCnt), 64'h0);
        checkOutput("wb3_busy_after", 64'(rs1Busy), 64'h0);

        // Collision on reg 9: set wins, data still written
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
        tick();
        checkOutput("col_pre_cnt", 64'(pendCnt), 64'h1);
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 5'd0, 5'd9);
        checkOutput("col_busy_same", 64'(rs2Busy), 64'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
        checkOutput("col_busy", 64'(rs2Busy), 64'h1);
        checkOutput("col_data", 64'(rs2Data), 64'h99);
        checkOutput("col_cnt", 64'(pendCnt), 64'h1);

        // Re-issue of an already pending register leaves the count alone
        applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd9);
        checkOutput("reiss_cnt", 64'(pendCnt), 64'h1);

        // Set 10 and clear 9 in one cycle: net count unchanged
        applyStimulus(1'b1, 5'd10, 1'b1, 5'd9, 32'h90, 5'd10, 5'd9);
        tick();
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd9);
        checkOutput("swap_cnt", 64'(pendCnt), 64'h1);
        checkOutput("swap_busy", 64'({rs1Busy, rs2Busy}), 64'h2);
        checkOutput("swap_data", 64'(rs2Data), 64'h90);

        // Build four pending registers, then reset between edges
        for (int r = 11; r <= 13; r++) begin
            applyStimulus(1'b1, 5'(r), 1'b1, 5'(r + 9), 32'(r), 5'd0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd20);
        checkOutput("pre_rst_cnt", 64'(pendCnt), 64'h4);
        checkOutput("pre_rst_data", 64'(rs2Data), 64'hB);
        checkOutput("pre_rst_busy", 64'(rs1Busy), 64'h1);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("async_cnt", 64'(pendCnt), 64'h0);
        checkOutput("async_busy", 64'(rs1Busy), 64'h0);
        checkOutput("async_data", 64'(rs2Data), 64'h0);
        rs1Addr = 5'd7;
        rs2Addr = 5'd5;
        #1;
        checkOutput("async_r7", 64'(rs1Data), 64'h0);
        checkOutput("async_r5", 64'(rs2Data), 64'h0);
        tick();
        rstN = 1'b1;
        #1;
        checkOutput("post_rst_r7", 64'(rs1Data), 64'h0);

        // Wide instance: release reset, fill all 15 non-zero registers
        bRstN = 1'b1;
        applyWide(1'b1, 4'd1, 1'b1, 4'd15, 64'hA5A5_0000_1234_5678, 4'd0, 4'd0);
        tick();
        for (int r = 2; r <= 4; r++) begin
            applyWide(1'b1, 4'(r), 1'b1, 4'(r + 4), 64'h1111_1111_0000_0000 * 64'(r), 4'd0, 4'd0);
            tick();
        end
        applyWide(1'b0, 4'd0, 1'b0, 4'd0, 64'h0, 4'd15, 4'd4);
        checkOutput("w_cnt4", 64'(bPendCnt), 64'h4);
        checkOutput("w_data15", bRs1Data, 64'hA5A5_0000_1234_5678);
        checkOutput("w_data7", 64'(dutWide.mem_q[7]), 64'h3333_3333_0000_0000);
        checkOutput("w_busy4", 64'(bRs2Busy), 64'h1);
        for (int r = 5; r <= 15; r++) begin
            applyWide(1'b1, 4'(r), 1'b0, 4'd0, 64'h0, 4'd0, 4'd0);
            tick();
        end
        applyWide(1'b1, 4'd0, 1'b0, 4'd0, 64'h0, 4'd15, 4'd0);
        tick();
        applyWide(1'b1, 4'd15, 1'b0, 4'd0, 64'h0, 4'd15, 4'd0);
        tick();
        applyWide(1'b0, 4'd0, 1'b0, 4'd0, 64'h0, 4'd15, 4'd0);
        checkOutput("w_cnt_full", 64'(bPendCnt), 64'hF);
        checkOutput("w_r0_busy", 64'(bRs2Busy), 64'h0);
        checkOutput("w_r15_busy", 64'(bRs1Busy), 64'h1);

        // Wide instance: asynchronous reset mid-stream
        #1;
        bRstN = 1'b0;
        #1;
        checkOutput("w_async_cnt", 64'(bPendCnt), 64'h0);
        checkOutput("w_async_data", bRs1Data, 64'h0);
        checkOutput("w_async_busy", 64'(bRs1Busy), 64'h0);
        tick();
        bRstN = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
